// File: rtl/maj_tt_pkg.sv
// Shared types for the majority truth-table sequencer: operand encoding,
// program-memory entry layout and sequencer states.
// No logic; latency/backpressure not applicable.
package maj_tt_pkg;

    localparam int NODES_MAX = 8;
    localparam int NIN       = 7;
    localparam int NODE_W    = 3;
    localparam int SRC_W     = 4;
    localparam int OPND_W    = SRC_W + 1;
    localparam int ENTRY_W   = 3 * OPND_W;
    localparam int NVEC      = 1 << NIN;

    // Operand source codes (low 4 bits of an operand field)
    localparam logic [SRC_W-1:0] SRC_X0        = 4'd0;
    localparam logic [SRC_W-1:0] SRC_X1        = 4'd1;
    localparam logic [SRC_W-1:0] SRC_X2        = 4'd2;
    localparam logic [SRC_W-1:0] SRC_X3        = 4'd3;
    localparam logic [SRC_W-1:0] SRC_X4        = 4'd4;
    localparam logic [SRC_W-1:0] SRC_X5        = 4'd5;
    localparam logic [SRC_W-1:0] SRC_X6        = 4'd6;
    localparam logic [SRC_W-1:0] SRC_ZERO      = 4'd7;
    localparam logic [SRC_W-1:0] SRC_NODE_BASE = 4'd8;

    // One operand: complement flag above the source select
    typedef struct packed {
        logic             inv;
        logic [SRC_W-1:0] src;
    } operand_t;

    // Program-memory entry, opA in the low bits
    typedef struct packed {
        operand_t op_c;
        operand_t op_b;
        operand_t op_a;
    } node_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/maj_tt_sequencer_if.sv
// Control/result bundle between a host and the truth-table sequencer.
// Pure wiring, zero latency; no backpressure (start/cfg are fire-and-forget).
// Optional MAJ_TT_ONESCNT_EN adds the tt_ones population count.
interface maj_tt_sequencer_if;
    logic         cfg_we;
    logic [2:0]   cfg_addr;
    logic [14:0]  cfg_data;
    logic [3:0]   num_nodes;
    logic         start;
    logic         busy;
    logic         done;
    logic         err;
    logic [127:0] tt;
    logic         tt_valid;
`ifdef MAJ_TT_ONESCNT_EN
    logic [7:0]   tt_ones;
`endif

    modport master (
        output cfg_we, cfg_addr, cfg_data, num_nodes, start,
`ifdef MAJ_TT_ONESCNT_EN
        input  tt_ones,
`endif
        input  busy, done, err, tt, tt_valid
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, num_nodes, start,
`ifdef MAJ_TT_ONESCNT_EN
        output tt_ones,
`endif
        output busy, done, err, tt, tt_valid
    );
endinterface

// File: rtl/maj3_unit.sv
// Shared 3-input majority with per-operand complement.
// Purely combinational, zero latency.
// No backpressure.
module maj3_unit (
    input  logic [2:0] i_op,
    input  logic [2:0] i_inv,
    output logic       o_maj
);
    logic [2:0] w_v;

    assign w_v   = i_op ^ i_inv;
    assign o_maj = (w_v[0] & w_v[1]) | (w_v[0] & w_v[2]) | (w_v[1] & w_v[2]);
endmodule

// File: rtl/maj_tt_sequencer.sv
// Sweeps all 128 input vectors through a programmable MAJ3 network, one node per cycle.
// Latency: done at cycle 128*num_nodes+1 after an accepted start.
// No backpressure; start while busy and cfg writes while busy are dropped.
// Optional MAJ_TT_ONESCNT_EN adds tt_ones, the running count of ones in tt.
module maj_tt_sequencer
    import maj_tt_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    maj_tt_sequencer_if.slave bus
);
    state_t               r_state;
    state_t               w_state_nxt;
    node_entry_t          r_mem [NODES_MAX];
    logic [NODES_MAX-1:0] r_node;
    logic [3:0]           r_n;
    logic [NODE_W-1:0]    r_k;
    logic [NIN-1:0]       r_v;
    logic [NVEC-1:0]      r_tt;
    logic                 r_tt_valid;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_reject;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_n_ok;
    logic                 w_last;
    logic                 w_final;
    logic                 w_res;
    logic [15:0]          w_src;
    node_entry_t          w_entry;

    // Source vector indexed directly by the 4-bit operand code: x0..x6, 0, nodes
    assign w_src   = {r_node, 1'b0, r_v};
    assign w_entry = r_mem[r_k];
    assign w_n_ok  = (bus.num_nodes != 4'd0) && (bus.num_nodes <= 4'(NODES_MAX));
    assign w_last  = ({1'b0, r_k} == (r_n - 4'd1));
    assign w_final = w_last && (r_v == 7'h7F);

    maj3_unit u_maj3 (
        .i_op  ({w_src[w_entry.op_c.src], w_src[w_entry.op_b.src], w_src[w_entry.op_a.src]}),
        .i_inv ({w_entry.op_c.inv, w_entry.op_b.inv, w_entry.op_a.inv}),
        .o_maj (w_res)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, start accept/reject decode and status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_n_ok) begin
                        w_accept    = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_reject    = 1'b1;
                    end
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_final) w_state_nxt = FIN;
            end
            FIN: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Program memory: writable only while idle, so a same-cycle start sees the new entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NODES_MAX; i++) r_mem[i] <= '0;
        end else if (r_state == IDLE && bus.cfg_we) begin
            r_mem[bus.cfg_addr] <= node_entry_t'(bus.cfg_data);
        end
    end

    // Sweep datapath: node registers, vector/node counters, truth table, error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_node     <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_v        <= '0;
            r_tt       <= '0;
            r_tt_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_n        <= bus.num_nodes;
                r_node     <= '0;
                r_tt       <= '0;
                r_tt_valid <= 1'b0;
                r_k        <= '0;
                r_v        <= '0;
            end else if (r_state == RUN) begin
                r_node[r_k] <= w_res;
                if (w_last) begin
                    r_tt[r_v] <= w_res;
                    r_k       <= '0;
                    r_v       <= r_v + 7'd1;
                end else begin
                    r_k <= r_k + 3'd1;
                end
                if (w_final) r_tt_valid <= 1'b1;
            end
        end
    end

`ifdef MAJ_TT_ONESCNT_EN
    logic [7:0] r_ones;

    // Population count tracks each 1 committed to the truth table
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     r_ones <= '0;
        else if (w_accept)                           r_ones <= '0;
        else if (r_state == RUN && w_last && w_res)  r_ones <= r_ones + 8'd1;
    end

    assign bus.tt_ones = r_ones;
`endif

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.err      = r_err;
    assign bus.tt       = r_tt;
    assign bus.tt_valid = r_tt_valid;
endmodule

// File: tb/tb_maj_tt_sequencer.sv
// Directed bench for maj_tt_sequencer with a done/err scoreboard.
module tb_maj_tt_sequencer;
    import maj_tt_pkg::*;

    typedef struct {
        bit           is_err;
        logic [127:0] tt;
        logic         ttv;
        int unsigned  cyc;
        int           ones;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int          done_seen = 0;
    exp_t        sb[$];
    exp_t        m_e;

    maj_tt_sequencer_if bus ();

    maj_tt_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [4:0] OX0 = {1'b0, SRC_X0};
    localparam logic [4:0] OX1 = {1'b0, SRC_X1};
    localparam logic [4:0] OX2 = {1'b0, SRC_X2};
    localparam logic [4:0] OX3 = {1'b0, SRC_X3};
    localparam logic [4:0] OX4 = {1'b0, SRC_X4};
    localparam logic [4:0] OX5 = {1'b0, SRC_X5};
    localparam logic [4:0] OX6 = {1'b0, SRC_X6};
    localparam logic [4:0] NX0 = {1'b1, SRC_X0};
    localparam logic [4:0] C0  = {1'b0, SRC_ZERO};
    localparam logic [4:0] C1  = {1'b1, SRC_ZERO};
    localparam logic [4:0] N0  = {1'b0, SRC_NODE_BASE};

    localparam logic [127:0] TT_MAJ  = {16{8'hE8}};
    localparam logic [127:0] TT_AND  = {32{4'h8}};
    localparam logic [127:0] TT_TWO  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h8888_8888_8888_8888};
    localparam logic [127:0] TT_SELF = {{127{1'b1}}, 1'b0};
    localparam logic [127:0] TT_NX0  = {32{4'h5}};
    localparam logic [127:0] TT_X6   = {{64{1'b1}}, {64{1'b0}}};

    function automatic logic [14:0] ent(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {c, b, a};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every done/err pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst === 1'b0 && (bus.done === 1'b1 || bus.err === 1'b1)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: done=%b err=%b, required no event", bus.done, bus.err);
            end else begin
                m_e = sb.pop_front();
                if (m_e.is_err) begin
                    check("err_pulse", {127'd0, bus.err}, 128'd1);
                    check("err_busy", {127'd0, bus.busy}, 128'd0);
                    check("err_tt_kept", bus.tt, m_e.tt);
                    check("err_tt_valid_kept", {127'd0, bus.tt_valid}, {127'd0, m_e.ttv});
                end else begin
                    check("done_pulse", {127'd0, bus.done}, 128'd1);
                    check("done_cycle", 128'(cyc - start_cyc), 128'(m_e.cyc));
                    check("done_busy", {127'd0, bus.busy}, 128'd0);
                    check("tt", bus.tt, m_e.tt);
                    check("tt_valid", {127'd0, bus.tt_valid}, {127'd0, m_e.ttv});
`ifdef MAJ_TT_ONESCNT_EN
                    check("tt_ones", 128'(bus.tt_ones), 128'(m_e.ones));
`endif
                    done_seen++;
                end
            end
        end
    end

    // All tasks are entered just after a falling edge and return just after one
    task automatic cfg(input logic [2:0] a, input logic [14:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic kick(input logic [3:0] n, input logic [127:0] t, input int ones, input bit push);
        exp_t e;
        e.is_err = 1'b0;
        e.tt     = t;
        e.ttv    = 1'b1;
        e.cyc    = 128 * n + 1;
        e.ones   = ones;
        bus.start     = 1'b1;
        bus.num_nodes = n;
        start_cyc     = cyc;
        if (push) sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic reject(input logic [3:0] n, input logic [127:0] t, input logic ttv);
        exp_t e;
        e.is_err = 1'b1;
        e.tt     = t;
        e.ttv    = ttv;
        e.cyc    = 0;
        e.ones   = 0;
        sb.push_back(e);
        bus.start     = 1'b1;
        bus.num_nodes = n;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_done(input int n);
        int b;
        b = done_seen;
        for (int i = 0; i < 128 * n + 10 && done_seen == b; i++) @(negedge clk);
        checks++;
        if (done_seen == b) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles, required a done pulse", 128 * n + 10);
        end
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.num_nodes = '0;
        bus.start     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {127'd0, bus.busy}, 128'd0);
        check("rst_done", {127'd0, bus.done}, 128'd0);
        check("rst_err", {127'd0, bus.err}, 128'd0);
        check("rst_tt", bus.tt, 128'd0);
        check("rst_tt_valid", {127'd0, bus.tt_valid}, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single MAJ(x0,x1,x2)
        cfg(3'd0, ent(OX0, OX1, OX2));
        kick(4'd1, TT_MAJ, 64, 1'b1);
        check("run_busy", {127'd0, bus.busy}, 128'd1);
        wait_done(1);

        // Out-of-range node counts are rejected and leave the result alone
        reject(4'd0, TT_MAJ, 1'b1);
        reject(4'd9, TT_MAJ, 1'b1);

        // AND via constant 0
        cfg(3'd0, ent(OX0, OX1, C0));
        kick(4'd1, TT_AND, 32, 1'b1);
        wait_done(1);

        // Two nodes: AND(x0,x1) | x6
        cfg(3'd1, ent(N0, OX6, C1));
        kick(4'd2, TT_TWO, 80, 1'b1);
        wait_done(2);

        // Self reference: node0 = node0_prev | x0
        cfg(3'd0, ent(N0, OX0, C1));
        kick(4'd1, TT_SELF, 127, 1'b1);
        wait_done(1);

        // Write and start in the same idle cycle: sweep uses ~x0
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd0;
        bus.cfg_data = ent(NX0, C0, C1);
        kick(4'd1, TT_NX0, 64, 1'b1);
        bus.cfg_we   = 1'b0;
        wait_done(1);

        // Full-size network: output node 7 = x6
        cfg(3'd7, ent(OX6, C0, C1));
        kick(4'd8, TT_X6, 64, 1'b1);
        wait_done(8);

        // Start and cfg write while running are both dropped
        cfg(3'd0, ent(OX0, OX1, C0));
        kick(4'd1, TT_AND, 32, 1'b1);
        repeat (50) @(negedge clk);
        bus.start     = 1'b1;
        bus.num_nodes = 4'd1;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 3'd0;
        bus.cfg_data  = ent(OX3, OX4, OX5);
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        wait_done(1);

        // Reset after ~40 vectors: everything cleared, no done follows
        cfg(3'd0, ent(OX0, OX1, OX2));
        kick(4'd1, TT_MAJ, 64, 1'b0);
        repeat (41) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {127'd0, bus.busy}, 128'd0);
        check("midrst_tt", bus.tt, 128'd0);
        check("midrst_tt_valid", {127'd0, bus.tt_valid}, 128'd0);
        check("midrst_done", {127'd0, bus.done}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        cfg(3'd0, ent(OX0, OX1, OX2));
        kick(4'd1, TT_MAJ, 64, 1'b1);
        wait_done(1);

        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/maj_tt_sequencer.md
Name: maj_tt_sequencer

Overview:
- Serial evaluator and truth-table sweeper for a programmable network of 3-input majority nodes over 7 inputs x0..x6.
- One shared MAJ3 unit is time-multiplexed across up to NODES_MAX nodes, one node per cycle, for all 128 input vectors.
- The result is a 128-bit truth table, the classification signature; bit v holds the output for input vector v, with x0 = LSB.
- Sits beside the combinational majority networks as their programmable, clocked checker and classifier.

Parameters:
- NODES_MAX, 8, maximum network size. Node index width is 3 bits; operand source field is 4 bits.
- NIN, 7, number of primary inputs (fixed at 7; 128 vectors).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  program-memory write strobe
- cfg_addr  in  3  node index to write
- cfg_data  in  15  node entry: three 5-bit operands {opC,opB,opA}, opA at [4:0]
- num_nodes  in  4  nodes used (1..NODES_MAX); sampled on accepted start
- start  in  1  start sweep (single-cycle pulse)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when sweep finishes
- err  out  1  one-cycle pulse when start is rejected
- tt  out  128  truth table
- tt_valid  out  1  tt holds a complete sweep result

Behaviour:
- Operand encoding: bit[4] = complement. Bits[3:0]: 0-6 select x0..x6 of the current vector; 7 = constant 0; 8+k = node register k.
- Node result = MAJ(a,b,c) on the post-complement operands. The network output is the result of node num_nodes-1.
- Reset (async): state IDLE; busy=0, done=0, err=0, tt=0, tt_valid=0; program memory and node registers cleared.
- States:
  - IDLE -> RUN on start with 1<=num_nodes<=NODES_MAX.
  - RUN -> FIN after node num_nodes-1 of vector 127.
  - FIN -> IDLE unconditionally.
- Accepted start, cycle 0:
  - latch num_nodes, clear node registers, tt, tt_valid; v=0, k=0.
  - busy=1 from cycle 1.
- RUN, each cycle: evaluate node k of vector v and write node register k.
  - If k==num_nodes-1: tt[v] <= result, k <= 0, v <= v+1 (7-bit).
  - Otherwise k <= k+1.
- Forward or self references (node index >= k) read the register's current contents: the previous vector's value, or 0 after start.
- FIN: done=1 and tt_valid=1 at cycle 128*num_nodes+1; busy=0 in that same cycle.
- Rejected start (num_nodes 0 or >NODES_MAX): err=1 next cycle, remain IDLE; tt and tt_valid unchanged.
- start while busy or in FIN: ignored, no err.
- cfg_we while busy: ignored. cfg_we in IDLE: memory written next edge.
- cfg_we and start in the same IDLE cycle: the write takes effect; the sweep uses the new entry.
- Reset mid-sweep: immediate return to IDLE with all outputs cleared; no done pulse.

Optional Feature:
- Macro MAJ_TT_ONESCNT_EN.
- Defined: adds output tt_ones[7:0], the count of ones in tt.
  - Incremented when a 1 is written to tt; cleared on start and reset.
  - Final value 0..128, valid with tt_valid.
- Undefined: port and counter absent; no other behavioural change.

Decomposition:
- Package maj_tt_pkg holds:
  - operand field widths and source constants (SRC_X0..SRC_X6, SRC_ZERO, SRC_NODE_BASE)
  - node entry packed typedef (three operand structs)
  - state enum {IDLE, RUN, FIN}
- One sub-module: maj3_unit, the combinational shared majority with per-operand complement. Instantiated once.

Test Plan:
- n=1, node0={x0,x1,x2} -> tt = 128'hE8 repeated 16 times; done at cycle 129; tt_valid=1.
- n=1, node0={x0,x1,const0} -> tt = 128'h8888...8888 (AND).
- n=2, node0={x0,x1,const0}, node1={node0,x6,~const0}:
  - tt = 128'hFFFFFFFFFFFFFFFF_8888888888888888
  - done at cycle 257
  - with MAJ_TT_ONESCNT_EN, tt_ones=80.
- start with num_nodes=0, then 9 -> err pulse each, busy stays 0, tt unchanged.
- Assert rst after 40 vectors -> busy=0, tt=0, tt_valid=0, no done; rerun of the first case gives correct tt.
- During a run, pulse start and cfg_we (node0={x3,x4,x5}) -> both ignored; result equals the original program's tt.
